// File: rtl/reg_file_mp.sv
// Two-read / one-write register file with a write-first bypass and a
// background clear sequencer that zeroes one entry per cycle.

module reg_file_mp_rport #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [AW-1:0]         raddr,
  input  logic                  wr_ok,
  input  logic [AW-1:0]         waddr,
  input  logic [W-1:0]          din,
  input  logic [DEPTH-1:0][W-1:0] mem,
  output logic [W-1:0]          dout,
  output logic                  rvalid,
  output logic                  oor
);
  localparam int NA = 1 << AW;
  localparam logic [NA-1:0] VALID = {NA{1'b1}} >> (NA - DEPTH);

  assign oor = en & ~VALID[raddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout   <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= en;
      if (en) begin
        if (!VALID[raddr])                   dout <= '0;
        else if (wr_ok && (waddr == raddr))  dout <= din;
        else                                 dout <= mem[raddr];
      end
    end
  end
endmodule

module reg_file_mp #(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  din,
  input  logic          ren0,
  input  logic          ren1,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  input  logic          clr,
  output logic [W-1:0]  dout0,
  output logic [W-1:0]  dout1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          busy,
  output logic          err
);
  localparam int NA = 1 << AW;
  localparam logic [NA-1:0] VALID = {NA{1'b1}} >> (NA - DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state, state_nx;
  logic [AW-1:0]           idx, idx_nx;
  logic [DEPTH-1:0][W-1:0] mem;
  logic                    wr_ok;
  logic [1:0]              ren_v, rvalid_v, oor_v;
  logic [1:0][AW-1:0]      raddr_v;
  logic [1:0][W-1:0]       dout_v;

  assign busy  = (state == CLEAR);
  // A clear request in the same cycle wins over the write.
  assign wr_ok = wen & ~busy & ~clr & VALID[waddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: if (clr) begin
        state_nx = CLEAR;
        idx_nx   = '0;
      end
      CLEAR: begin
        idx_nx = idx + AW'(1);
        if (idx == LAST) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (busy) begin
      mem[idx] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= din;
    end
  end

  // All fault sources of one cycle merge into a single pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= ~busy & ((wen & ~VALID[waddr]) | (|oor_v));
  end

  assign ren_v   = {ren1, ren0};
  assign raddr_v = {raddr1, raddr0};

  for (genvar k = 0; k < 2; k++) begin : g_rport
    reg_file_mp_rport #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_rport (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (ren_v[k] & ~busy),
      .raddr  (raddr_v[k]),
      .wr_ok  (wr_ok),
      .waddr  (waddr),
      .din    (din),
      .mem    (mem),
      .dout   (dout_v[k]),
      .rvalid (rvalid_v[k]),
      .oor    (oor_v[k])
    );
  end

  assign dout0   = dout_v[0];
  assign dout1   = dout_v[1];
  assign rvalid0 = rvalid_v[0];
  assign rvalid1 = rvalid_v[1];
endmodule
